alu_issue_seq: RTL and testbench
================================

Name: alu_issue_seq

Overview:
Issue stage directly upstream of the 32-bit ALU. Accepts register-to-register or register-immediate commands over a valid/ready handshake and reads operands from an internal register file. Drives the ALU X/Y/op_code inputs, captures Z and the ALU flags, writes Z back to the destination register, and returns a response over a second valid/ready handshake. Serial, one command in flight at a time.

Parameters:
NUM_REGS, 16, register file depth; must be a power of two, at least 2.
RA_W, 4, register address width; equals log2(NUM_REGS).

Ports:
clk  input  1  sole clock; all state updates on rising edge
rst_n  input  1  synchronous, active-low reset
cmd_valid  input  1  command offered
cmd_ready  output  1  stage can accept a command (high only in IDLE)
cmd_op  input  4  ALU op code: AND=0000 OR=0001 XOR=0010 NOR=0011 ADD=0101 SUB=0110 SLT=0111 SRL=1000 SLL=1001 SRA=1010
cmd_rd  input  RA_W  destination register
cmd_rs  input  RA_W  source register, drives X
cmd_rt  input  RA_W  source register, drives Y when cmd_imm_sel=0
cmd_imm_sel  input  1  1: Y comes from cmd_imm
cmd_imm  input  32  immediate operand
alu_X  output  32  to ALU X (registered)
alu_Y  output  32  to ALU Y (registered)
alu_op  output  4  to ALU op_code (registered)
alu_Z  input  32  from ALU Z (combinational ALU)
alu_overflow  input  1  from ALU
alu_equal  input  1  from ALU
alu_zero  input  1  from ALU
rsp_valid  output  1  response available
rsp_ready  input  1  consumer accepts response
rsp_data  output  32  captured Z
rsp_flags  output  3  {overflow, equal, zero} captured
rsp_err  output  1  command rejected (illegal op code)
dbg_addr  input  RA_W  debug read address
dbg_data  output  32  combinational read of register file

Behaviour:
- Reset (rst_n=0 at a clock edge, any state): FSM goes to IDLE; all registers cleared to 0. Reset outputs: cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_flags=0, rsp_err=0, alu_X=0, alu_Y=0, alu_op=0. Reset mid-command abandons the command: no writeback and no response.
- Register 0 reads as 0 always; writes to r0 are discarded. The response still reports Z.
- FSM has three states: IDLE, EXEC, RESP.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready (cycle T):
  - Legal op: latch alu_X=R[rs]; alu_Y=cmd_imm_sel?cmd_imm:R[rt]; alu_op=cmd_op; latch rd; go to EXEC.
  - Illegal op (0100, 1011–1111): no ALU issue; rsp_err=1, rsp_data=0, rsp_flags=0; go to RESP. alu_* outputs hold their previous values.
- EXEC (cycle T+1): ALU outputs are sampled at the end of this cycle.
  - R[rd]<=alu_Z (unless rd=0).
  - rsp_data<=alu_Z; rsp_flags<={alu_overflow,alu_equal,alu_zero}; rsp_err<=0.
  - Go to RESP. cmd_ready=0.
- RESP: rsp_valid=1; hold all rsp_* stable until rsp_ready. On rsp_valid&rsp_ready go to IDLE. cmd_ready=0, so a new command is never accepted in the same cycle as the response handshake.
- Timing: response visible at T+2 at the earliest. Throughput is one command per 3 cycles with rsp_ready held high.
- Operand read uses the register file contents at cycle T. The prior command's writeback has completed by then, so no hazards exist.
- dbg_data=R[dbg_addr] combinationally. It reflects a writeback on the cycle after EXEC.
- alu_X/alu_Y/alu_op hold their values after EXEC until the next legal issue.

Decomposition:
- Shared package alu_defs holds the op-code constants (OP_AND…OP_SRA), an op-legal function, and flag bit positions (FLAG_OVF=2, FLAG_EQ=1, FLAG_Z=0).
- One sub-module, alu_regfile: NUM_REGS×32, two combinational read ports plus the debug read port, one synchronous write port, r0 hardwired to zero.
- The FSM stays in alu_issue_seq. The bench instantiates the real ALU against alu_* ports.

Test Plan:
- Reset, then OR r1,r0,imm=1 and OR r2,r0,imm=2, then ADD r3,r1,r2 -> alu_X=1 and alu_Y=2 at T+1; rsp at T+2: rsp_data=3, flags=000; dbg_addr=3 reads 3.
- SUB r4,r1,r1 -> rsp_data=0, flags=011 (equal, zero). ADD r5 with r1=0x7FFFFFFF and imm 1 -> rsp_data=0x80000000, overflow=1.
- cmd_op=4'b1100 -> no ALU issue (alu_op unchanged); rsp at T+1 with rsp_err=1, rsp_data=0; register file unchanged.
- Hold rsp_ready=0 for 5 cycles with cmd_valid asserted -> rsp_* stable and cmd_ready=0 throughout; the next command is accepted only after the handshake.
- ADD r0,r1,r2 -> rsp_data=3 but dbg r0 stays 0. SRA r6,r(0x80000000),imm 4 -> 0xF8000000.
- rst_n=0 during EXEC -> next cycle IDLE, rsp_valid=0, all regs 0, no writeback.

Source files
------------

// File: rtl/alu_issue_seq_pkg.sv
// Shared definitions for the ALU issue stage: op codes, flag bit positions,
// FSM state type and the op-legality check.
package alu_defs;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;
  localparam logic [3:0] OP_NOR = 4'b0011;
  localparam logic [3:0] OP_ADD = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_SRL = 4'b1000;
  localparam logic [3:0] OP_SLL = 4'b1001;
  localparam logic [3:0] OP_SRA = 4'b1010;

  localparam int FLAG_OVF = 2;
  localparam int FLAG_EQ  = 1;
  localparam int FLAG_Z   = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic logic op_legal(input logic [3:0] op);
    logic legal;
    case (op)
      OP_AND, OP_OR, OP_XOR, OP_NOR, OP_ADD,
      OP_SUB, OP_SLT, OP_SRL, OP_SLL, OP_SRA: legal = 1'b1;
      default:                                legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/alu_issue_seq_if.sv
// Command, ALU, response and debug signals of the issue stage. The slave
// modport is the issue stage itself; master is its surrounding environment.
interface alu_issue_seq_if #(
  parameter int RA_W = 4
);

  logic            cmd_valid;
  logic            cmd_ready;
  logic [3:0]      cmd_op;
  logic [RA_W-1:0] cmd_rd;
  logic [RA_W-1:0] cmd_rs;
  logic [RA_W-1:0] cmd_rt;
  logic            cmd_imm_sel;
  logic [31:0]     cmd_imm;

  logic [31:0]     alu_X;
  logic [31:0]     alu_Y;
  logic [3:0]      alu_op;
  logic [31:0]     alu_Z;
  logic            alu_overflow;
  logic            alu_equal;
  logic            alu_zero;

  logic            rsp_valid;
  logic            rsp_ready;
  logic [31:0]     rsp_data;
  logic [2:0]      rsp_flags;
  logic            rsp_err;

  logic [RA_W-1:0] dbg_addr;
  logic [31:0]     dbg_data;

  modport slave (
    input  cmd_valid, cmd_op, cmd_rd, cmd_rs, cmd_rt, cmd_imm_sel, cmd_imm,
    input  alu_Z, alu_overflow, alu_equal, alu_zero,
    input  rsp_ready, dbg_addr,
    output cmd_ready, alu_X, alu_Y, alu_op,
    output rsp_valid, rsp_data, rsp_flags, rsp_err, dbg_data
  );

  modport master (
    output cmd_valid, cmd_op, cmd_rd, cmd_rs, cmd_rt, cmd_imm_sel, cmd_imm,
    output alu_Z, alu_overflow, alu_equal, alu_zero,
    output rsp_ready, dbg_addr,
    input  cmd_ready, alu_X, alu_Y, alu_op,
    input  rsp_valid, rsp_data, rsp_flags, rsp_err, dbg_data
  );

endinterface

// File: rtl/alu_issue_seq_regfile.sv
// NUM_REGS x 32 register file: two operand read ports, one debug read port,
// one synchronous write port; r0 is hardwired to zero.
module alu_regfile #(
  parameter int NUM_REGS = 16,
  parameter int RA_W     = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we_i,
  input  logic [RA_W-1:0] waddr_i,
  input  logic [31:0]     wdata_i,
  input  logic [RA_W-1:0] raddr_a_i,
  output logic [31:0]     rdata_a_o,
  input  logic [RA_W-1:0] raddr_b_i,
  output logic [31:0]     rdata_b_o,
  input  logic [RA_W-1:0] dbg_addr_i,
  output logic [31:0]     dbg_data_o
);

  logic [31:0] mem_q [NUM_REGS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != '0)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Address 0 is forced to zero on every read port regardless of storage.
  assign rdata_a_o  = (raddr_a_i  == '0) ? '0 : mem_q[raddr_a_i];
  assign rdata_b_o  = (raddr_b_i  == '0) ? '0 : mem_q[raddr_b_i];
  assign dbg_data_o = (dbg_addr_i == '0) ? '0 : mem_q[dbg_addr_i];

endmodule

// File: rtl/alu_issue_seq.sv
// Serial issue stage in front of the 32-bit ALU: reads operands, drives the
// ALU, captures Z and flags, writes Z back and returns a response.
module alu_issue_seq
  import alu_defs::*;
#(
  parameter int NUM_REGS = 16,
  parameter int RA_W     = 4
) (
  input logic            clk,
  input logic            rst_n,
  alu_issue_seq_if.slave bus
);

  state_e          state_q;
  logic            cmd_ready_q;
  logic            rsp_valid_q;
  logic [31:0]     rsp_data_q;
  logic [2:0]      rsp_flags_q;
  logic            rsp_err_q;
  logic [31:0]     alu_x_q;
  logic [31:0]     alu_y_q;
  logic [3:0]      alu_op_q;
  logic [RA_W-1:0] rd_q;

  logic [31:0]     rs_data;
  logic [31:0]     rt_data;
  logic            wb_en;

  // The ALU result is only valid while EXEC presents the latched operands.
  assign wb_en = (state_q == ST_EXEC);

  alu_regfile #(
    .NUM_REGS (NUM_REGS),
    .RA_W     (RA_W)
  ) u_regfile (
    .clk        (clk),
    .rst_n      (rst_n),
    .we_i       (wb_en),
    .waddr_i    (rd_q),
    .wdata_i    (bus.alu_Z),
    .raddr_a_i  (bus.cmd_rs),
    .rdata_a_o  (rs_data),
    .raddr_b_i  (bus.cmd_rt),
    .rdata_b_o  (rt_data),
    .dbg_addr_i (bus.dbg_addr),
    .dbg_data_o (bus.dbg_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_flags_q <= '0;
      rsp_err_q   <= 1'b0;
      alu_x_q     <= '0;
      alu_y_q     <= '0;
      alu_op_q    <= '0;
      rd_q        <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.cmd_valid && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            if (op_legal(bus.cmd_op)) begin
              alu_x_q  <= rs_data;
              alu_y_q  <= bus.cmd_imm_sel ? bus.cmd_imm : rt_data;
              alu_op_q <= bus.cmd_op;
              rd_q     <= bus.cmd_rd;
              state_q  <= ST_EXEC;
            end else begin
              // Rejected commands skip the ALU and answer one cycle early.
              rsp_err_q   <= 1'b1;
              rsp_data_q  <= '0;
              rsp_flags_q <= '0;
              rsp_valid_q <= 1'b1;
              state_q     <= ST_RESP;
            end
          end
        end
        ST_EXEC: begin
          rsp_data_q            <= bus.alu_Z;
          rsp_flags_q[FLAG_OVF] <= bus.alu_overflow;
          rsp_flags_q[FLAG_EQ]  <= bus.alu_equal;
          rsp_flags_q[FLAG_Z]   <= bus.alu_zero;
          rsp_err_q             <= 1'b0;
          rsp_valid_q           <= 1'b1;
          state_q               <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          cmd_ready_q <= 1'b1;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_flags = rsp_flags_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.alu_X     = alu_x_q;
  assign bus.alu_Y     = alu_y_q;
  assign bus.alu_op    = alu_op_q;

endmodule

// File: tb/tb_alu_issue_seq.sv
// Self-checking bench for alu_issue_seq: behavioural ALU on the alu_* side,
// register-file reference model, directed scenarios plus random commands.
module tb_alu_issue_seq;

  logic clk;
  logic rst_n;
  int   testsRun;
  int   testsFailed;

  logic [31:0] modelRegs [16];

  alu_issue_seq_if #(.RA_W(4)) bus ();

  alu_issue_seq #(
    .NUM_REGS (16),
    .RA_W     (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Returns {overflow, equal, zero, Z} from plain signed/unsigned arithmetic.
  function automatic logic [34:0] alu_eval(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] z;
    logic        ovf;
    longint      wide;
    z   = '0;
    ovf = 1'b0;
    case (op)
      4'd0: z = x & y;
      4'd1: z = x | y;
      4'd2: z = x ^ y;
      4'd3: z = ~(x | y);
      4'd5: begin
        wide = longint'($signed(x)) + longint'($signed(y));
        z    = x + y;
        ovf  = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
      end
      4'd6: begin
        wide = longint'($signed(x)) - longint'($signed(y));
        z    = x - y;
        ovf  = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
      end
      4'd7:  z = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd8:  z = x >> y[4:0];
      4'd9:  z = x << y[4:0];
      4'd10: z = $unsigned($signed(x) >>> y[4:0]);
      default: z = '0;
    endcase
    return {ovf, (x == y), (z == 32'd0), z};
  endfunction

  always_comb begin
    {bus.alu_overflow, bus.alu_equal, bus.alu_zero, bus.alu_Z} = alu_eval(bus.alu_op, bus.alu_X, bus.alu_Y);
  end

  // Reference model step: returns {err, ovf, eq, zero, data} and updates the model.
  function automatic logic [35:0] model_step(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs,
                                             input logic [3:0] rt, input logic sel, input logic [31:0] imm);
    logic [34:0] r;
    if (!(op inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10})) return {1'b1, 35'd0};
    r = alu_eval(op, modelRegs[rs], sel ? imm : modelRegs[rt]);
    if (rd != 4'd0) modelRegs[rd] = r[31:0];
    return {1'b0, r};
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 16; i++) modelRegs[i] = '0;
  endfunction

  // Drives one command, captures ALU inputs at T+1 and the response, completes the handshake.
  task automatic do_cmd(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs, input logic [3:0] rt,
                        input logic sel, input logic [31:0] imm,
                        output logic [31:0] xSeen, output logic [31:0] ySeen, output logic [3:0] opSeen,
                        output logic [31:0] data, output logic [2:0] flags, output logic err,
                        output int lat, output logic tmo);
    int n;
    tmo = 1'b0;
    @(negedge clk);
    bus.cmd_op = op; bus.cmd_rd = rd; bus.cmd_rs = rs; bus.cmd_rt = rt;
    bus.cmd_imm_sel = sel; bus.cmd_imm = imm; bus.cmd_valid = 1'b1;
    n = 0;
    while (!bus.cmd_ready && n < 20) begin @(negedge clk); n++; end
    if (!bus.cmd_ready) begin
      tmo = 1'b1; bus.cmd_valid = 1'b0;
      xSeen = '0; ySeen = '0; opSeen = '0; data = '0; flags = '0; err = 1'b0; lat = 0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    xSeen = bus.alu_X; ySeen = bus.alu_Y; opSeen = bus.alu_op;
    lat = 1;
    while (!bus.rsp_valid && lat < 10) begin @(negedge clk); lat++; end
    if (!bus.rsp_valid) tmo = 1'b1;
    data = bus.rsp_data; flags = bus.rsp_flags; err = bus.rsp_err;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    testsRun++;
    if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.rsp_err !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_ctrl: ready/valid/err = %b%b%b, want 100", bus.cmd_ready, bus.rsp_valid, bus.rsp_err);
    end
    testsRun++;
    if (bus.rsp_data !== 32'd0 || bus.rsp_flags !== 3'd0) begin
      testsFailed++;
      $display("[TB] FAIL reset_rsp: data=%h flags=%b, want 0/000", bus.rsp_data, bus.rsp_flags);
    end
    testsRun++;
    if (bus.alu_X !== 32'd0 || bus.alu_Y !== 32'd0 || bus.alu_op !== 4'd0) begin
      testsFailed++;
      $display("[TB] FAIL reset_alu: X=%h Y=%h op=%h, want all 0", bus.alu_X, bus.alu_Y, bus.alu_op);
    end
  endtask

  task automatic test_basic();
    logic [31:0] x, y, d; logic [3:0] o; logic [2:0] f; logic e, t; int lat; logic [35:0] exp;
    exp = model_step(4'd1, 4'd1, 4'd0, 4'd0, 1'b1, 32'd1);
    do_cmd(4'd1, 4'd1, 4'd0, 4'd0, 1'b1, 32'd1, x, y, o, d, f, e, lat, t);
    exp = model_step(4'd1, 4'd2, 4'd0, 4'd0, 1'b1, 32'd2);
    do_cmd(4'd1, 4'd2, 4'd0, 4'd0, 1'b1, 32'd2, x, y, o, d, f, e, lat, t);
    exp = model_step(4'd5, 4'd3, 4'd1, 4'd2, 1'b0, 32'd0);
    do_cmd(4'd5, 4'd3, 4'd1, 4'd2, 1'b0, 32'd0, x, y, o, d, f, e, lat, t);
    testsRun++;
    if (t || x !== 32'd1 || y !== 32'd2 || o !== 4'd5) begin
      testsFailed++;
      $display("[TB] FAIL add_issue: X=%h Y=%h op=%h tmo=%b, want 1/2/5", x, y, o, t);
    end
    testsRun++;
    if (lat !== 2 || d !== 32'd3 || f !== 3'b000 || e !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL add_rsp: lat=%0d data=%h flags=%b err=%b, want 2/3/000/0", lat, d, f, e);
    end
    bus.dbg_addr = 4'd3; #1;
    testsRun++;
    if (bus.dbg_data !== 32'd3) begin
      testsFailed++;
      $display("[TB] FAIL add_wb: dbg r3=%h, want 3", bus.dbg_data);
    end
  endtask

  task automatic test_arith();
    logic [31:0] x, y, d; logic [3:0] o; logic [2:0] f; logic e, t; int lat; logic [35:0] exp;
    exp = model_step(4'd6, 4'd4, 4'd1, 4'd1, 1'b0, 32'd0);
    do_cmd(4'd6, 4'd4, 4'd1, 4'd1, 1'b0, 32'd0, x, y, o, d, f, e, lat, t);
    testsRun++;
    if (t || d !== 32'd0 || f !== 3'b011) begin
      testsFailed++;
      $display("[TB] FAIL sub_equal: data=%h flags=%b, want 0/011", d, f);
    end
    exp = model_step(4'd1, 4'd1, 4'd0, 4'd0, 1'b1, 32'h7FFF_FFFF);
    do_cmd(4'd1, 4'd1, 4'd0, 4'd0, 1'b1, 32'h7FFF_FFFF, x, y, o, d, f, e, lat, t);
    exp = model_step(4'd5, 4'd5, 4'd1, 4'd0, 1'b1, 32'd1);
    do_cmd(4'd5, 4'd5, 4'd1, 4'd0, 1'b1, 32'd1, x, y, o, d, f, e, lat, t);
    testsRun++;
    if (t || d !== 32'h8000_0000 || f !== 3'b100) begin
      testsFailed++;
      $display("[TB] FAIL add_ovf: data=%h flags=%b, want 80000000/100", d, f);
    end
  endtask

  task automatic test_illegal();
    logic [31:0] x, y, d; logic [3:0] o; logic [2:0] f; logic e, t; int lat; logic [35:0] exp;
    logic [3:0] prevOp;
    prevOp = bus.alu_op;
    exp = model_step(4'b1100, 4'd7, 4'd1, 4'd2, 1'b0, 32'd0);
    do_cmd(4'b1100, 4'd7, 4'd1, 4'd2, 1'b0, 32'd0, x, y, o, d, f, e, lat, t);
    testsRun++;
    if (t || lat !== 1 || e !== 1'b1 || d !== 32'd0 || f !== 3'd0) begin
      testsFailed++;
      $display("[TB] FAIL illegal_rsp: lat=%0d err=%b data=%h flags=%b, want 1/1/0/000", lat, e, d, f);
    end
    testsRun++;
    if (o !== 4'd5 || prevOp !== 4'd5) begin
      testsFailed++;
      $display("[TB] FAIL illegal_noissue: alu_op=%h before=%h, want 5", o, prevOp);
    end
    bus.dbg_addr = 4'd7; #1;
    testsRun++;
    if (bus.dbg_data !== modelRegs[7]) begin
      testsFailed++;
      $display("[TB] FAIL illegal_nowb: dbg r7=%h, want %h", bus.dbg_data, modelRegs[7]);
    end
  endtask

  task automatic test_r0_sra();
    logic [31:0] x, y, d; logic [3:0] o; logic [2:0] f; logic e, t; int lat; logic [35:0] exp;
    exp = model_step(4'd1, 4'd1, 4'd0, 4'd0, 1'b1, 32'd1);
    do_cmd(4'd1, 4'd1, 4'd0, 4'd0, 1'b1, 32'd1, x, y, o, d, f, e, lat, t);
    exp = model_step(4'd5, 4'd0, 4'd1, 4'd2, 1'b0, 32'd0);
    do_cmd(4'd5, 4'd0, 4'd1, 4'd2, 1'b0, 32'd0, x, y, o, d, f, e, lat, t);
    bus.dbg_addr = 4'd0; #1;
    testsRun++;
    if (t || d !== 32'd3 || bus.dbg_data !== 32'd0) begin
      testsFailed++;
      $display("[TB] FAIL r0_write: data=%h dbg r0=%h, want 3/0", d, bus.dbg_data);
    end
    exp = model_step(4'd1, 4'd9, 4'd0, 4'd0, 1'b1, 32'h8000_0000);
    do_cmd(4'd1, 4'd9, 4'd0, 4'd0, 1'b1, 32'h8000_0000, x, y, o, d, f, e, lat, t);
    exp = model_step(4'd10, 4'd6, 4'd9, 4'd0, 1'b1, 32'd4);
    do_cmd(4'd10, 4'd6, 4'd9, 4'd0, 1'b1, 32'd4, x, y, o, d, f, e, lat, t);
    bus.dbg_addr = 4'd6; #1;
    testsRun++;
    if (t || d !== 32'hF800_0000 || bus.dbg_data !== 32'hF800_0000) begin
      testsFailed++;
      $display("[TB] FAIL sra: data=%h dbg r6=%h, want F8000000", d, bus.dbg_data);
    end
  endtask

  task automatic test_backpressure();
    logic [35:0] expA, expB;
    logic [31:0] holdData; logic [2:0] holdFlags;
    int n;
    logic sawBad;
    expA = model_step(4'd5, 4'd10, 4'd1, 4'd2, 1'b0, 32'd0);
    @(negedge clk);
    bus.cmd_op = 4'd5; bus.cmd_rd = 4'd10; bus.cmd_rs = 4'd1; bus.cmd_rt = 4'd2;
    bus.cmd_imm_sel = 1'b0; bus.cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_op = 4'd2; bus.cmd_rd = 4'd11; bus.cmd_rs = 4'd1; bus.cmd_imm_sel = 1'b1; bus.cmd_imm = 32'hFF;
    n = 0;
    while (!bus.rsp_valid && n < 10) begin @(negedge clk); n++; end
    holdData = bus.rsp_data; holdFlags = bus.rsp_flags;
    testsRun++;
    if (!bus.rsp_valid || holdData !== expA[31:0]) begin
      testsFailed++;
      $display("[TB] FAIL bp_first: valid=%b data=%h, want 1/%h", bus.rsp_valid, holdData, expA[31:0]);
    end
    sawBad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!bus.rsp_valid || bus.cmd_ready || bus.rsp_data !== holdData || bus.rsp_flags !== holdFlags) sawBad = 1'b1;
    end
    testsRun++;
    if (sawBad) begin
      testsFailed++;
      $display("[TB] FAIL bp_hold: rsp changed or cmd_ready rose, sawBad=%b want 0", sawBad);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    testsRun++;
    if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL bp_idle: ready=%b valid=%b, want 1/0", bus.cmd_ready, bus.rsp_valid);
    end
    expB = model_step(4'd2, 4'd11, 4'd1, 4'd0, 1'b1, 32'hFF);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    testsRun++;
    if (bus.alu_X !== 32'd1 || bus.alu_Y !== 32'hFF || bus.alu_op !== 4'd2) begin
      testsFailed++;
      $display("[TB] FAIL bp_second_issue: X=%h Y=%h op=%h, want 1/ff/2", bus.alu_X, bus.alu_Y, bus.alu_op);
    end
    n = 0;
    while (!bus.rsp_valid && n < 10) begin @(negedge clk); n++; end
    testsRun++;
    if (!bus.rsp_valid || bus.rsp_data !== expB[31:0]) begin
      testsFailed++;
      $display("[TB] FAIL bp_second: valid=%b data=%h, want 1/%h", bus.rsp_valid, bus.rsp_data, expB[31:0]);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] x, y, d, imm, expX, expY; logic [3:0] o, op, rd, rs, rt; logic [2:0] f; logic e, t, sel;
    int lat; logic [35:0] exp;
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15)); rd = 4'($urandom_range(0, 15));
      rs = 4'($urandom_range(0, 15)); rt = 4'($urandom_range(0, 15));
      sel = 1'($urandom_range(0, 1)); imm = $urandom;
      if (i % 5 == 0) imm = 32'hFFFF_FFFF;
      expX = modelRegs[rs];
      expY = sel ? imm : modelRegs[rt];
      exp  = model_step(op, rd, rs, rt, sel, imm);
      do_cmd(op, rd, rs, rt, sel, imm, x, y, o, d, f, e, lat, t);
      testsRun++;
      if (t || e !== exp[35] || d !== exp[31:0] || f !== exp[34:32] || lat !== (exp[35] ? 1 : 2)) begin
        testsFailed++;
        $display("[TB] FAIL rand_rsp[%0d] op=%h: err=%b data=%h flags=%b lat=%0d, want %b/%h/%b/%0d",
                 i, op, e, d, f, lat, exp[35], exp[31:0], exp[34:32], exp[35] ? 1 : 2);
      end
      if (!exp[35]) begin
        testsRun++;
        if (x !== expX || y !== expY) begin
          testsFailed++;
          $display("[TB] FAIL rand_issue[%0d]: X=%h Y=%h, want %h/%h", i, x, y, expX, expY);
        end
      end
      bus.dbg_addr = rd; #1;
      testsRun++;
      if (bus.dbg_data !== modelRegs[rd]) begin
        testsFailed++;
        $display("[TB] FAIL rand_wb[%0d]: dbg r%0d=%h, want %h", i, rd, bus.dbg_data, modelRegs[rd]);
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.cmd_op = 4'd1; bus.cmd_rd = 4'd12; bus.cmd_rs = 4'd0; bus.cmd_imm_sel = 1'b1;
    bus.cmd_imm = 32'hDEAD_BEEF; bus.cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    testsRun++;
    if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.alu_X !== 32'd0 || bus.alu_Y !== 32'd0) begin
      testsFailed++;
      $display("[TB] FAIL mid_reset: ready=%b valid=%b X=%h Y=%h, want 1/0/0/0",
               bus.cmd_ready, bus.rsp_valid, bus.alu_X, bus.alu_Y);
    end
    for (int i = 0; i < 16; i++) begin
      bus.dbg_addr = 4'(i); #1;
      testsRun++;
      if (bus.dbg_data !== modelRegs[i]) begin
        testsFailed++;
        $display("[TB] FAIL mid_reset_reg: r%0d=%h, want %h", i, bus.dbg_data, modelRegs[i]);
      end
    end
    @(negedge clk);
    testsRun++;
    if (bus.rsp_valid !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL mid_reset_norsp: rsp_valid=%b, want 0", bus.rsp_valid);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, time=%0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    testsRun = 0; testsFailed = 0;
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_rd = '0; bus.cmd_rs = '0; bus.cmd_rt = '0;
    bus.cmd_imm_sel = 1'b0; bus.cmd_imm = '0; bus.rsp_ready = 1'b0; bus.dbg_addr = '0;
    model_clear();
    test_reset();
    test_basic();
    test_arith();
    test_illegal();
    test_r0_sra();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
